// File: rtl/arbitro_memoria_if.sv
// Bundles the requester, VGA and board-memory signals of the memory arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and memories around it.
interface arbitro_memoria_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);

  // Requester side: three requesters packed by index (0 validador, 1 colisor, 2 pontuacao)
  logic [2:0]          req;
  logic [2:0]          req_we;
  logic [2:0]          req_jogador;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_wdata;
  logic [2:0]          ack;
  logic                erro;
  logic [DATA_W-1:0]   rdata;

  // VGA read port, served whenever the arbiter is idle
  logic [ADDR_W-1:0]   vga_addr;
  logic                vga_jogador;
  logic [DATA_W-1:0]   vga_data;
  logic                vga_valid;

  // Shared address/data bus to the two player memories
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_data;
  logic                wrenP1;
  logic                wrenP2;
  logic [DATA_W-1:0]   mem_q1;
  logic [DATA_W-1:0]   mem_q2;

  logic                busy;

  modport slave (
    input  req, req_we, req_jogador, req_addr, req_wdata,
    output ack, erro, rdata,
    input  vga_addr, vga_jogador,
    output vga_data, vga_valid,
    output mem_addr, mem_data, wrenP1, wrenP2,
    input  mem_q1, mem_q2,
    output busy
  );

  modport master (
    output req, req_we, req_jogador, req_addr, req_wdata,
    input  ack, erro, rdata,
    output vga_addr, vga_jogador,
    input  vga_data, vga_valid,
    input  mem_addr, mem_data, wrenP1, wrenP2,
    output mem_q1, mem_q2,
    input  busy
  );

endinterface

// File: rtl/arbitro_memoria.sv
// Round-robin arbiter that gives three requesters and a VGA reader access to two board memories.
// Latency: a request latched at edge N is acknowledged, with erro and rdata, in the cycle after edge N+2.
// Backpressure: requesters hold req until they are latched. The VGA port is served only in IDLE cycles.
module arbitro_memoria #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int MAX_ADDR = 10
) (
  input  logic              clk,
  input  logic              resetGeral,
  arbitro_memoria_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam int unsigned MAX_A = MAX_ADDR;

  state_t              state_q, state_d;

  // Round-robin pointer: the index of the requester granted most recently
  logic [1:0]          last_q;

  // Transaction latched when a request wins in IDLE
  logic [1:0]          win_q;
  logic                we_q;
  logic                jog_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Registered response
  logic [2:0]          ack_q;
  logic                erro_q;
  logic [DATA_W-1:0]   rdata_q;

  // VGA pipeline: marks a cycle whose mem_q comes from a VGA address
  logic                vga_valid_q;
  logic                vga_jog_q;
  logic [DATA_W-1:0]   vga_hold_q;
  logic [DATA_W-1:0]   vga_data_c;

  // Arbitration and selection
  logic [1:0]          cand0, cand1, cand2;
  logic [1:0]          pick;
  logic                sel_we;
  logic                sel_jog;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                any_req;
  logic                addr_ok;

  // Datapath driven by the FSM
  logic [ADDR_W-1:0]   mem_addr_c;
  logic                wren_p1_c;
  logic                wren_p2_c;
  logic                busy_c;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  assign any_req = |bus.req;
  assign addr_ok = (32'(addr_q) <= MAX_A);

  // Round-robin search that starts at the requester after the last one granted
  always_comb begin
    cand0 = rr_next(last_q);
    cand1 = rr_next(cand0);
    cand2 = rr_next(cand1);
    pick  = cand0;
    if (bus.req[cand0]) begin
      pick = cand0;
    end else if (bus.req[cand1]) begin
      pick = cand1;
    end else if (bus.req[cand2]) begin
      pick = cand2;
    end
  end

  // Mux the winner's command fields out of the packed request buses
  always_comb begin
    sel_we    = 1'b0;
    sel_jog   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (pick == 2'(i)) begin
        sel_we    = bus.req_we[i];
        sel_jog   = bus.req_jogador[i];
        sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and memory-bus control. The VGA address owns the bus whenever the FSM is idle.
  always_comb begin
    state_d    = state_q;
    mem_addr_c = bus.vga_addr;
    wren_p1_c  = 1'b0;
    wren_p2_c  = 1'b0;
    busy_c     = 1'b1;
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (any_req) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr_c = addr_q;
        wren_p1_c  = we_q & ~jog_q & addr_ok;
        wren_p2_c  = we_q &  jog_q & addr_ok;
        state_d    = ACK;
      end
      ACK: begin
        // Keep the address stable while the read data from ACCESS is captured
        mem_addr_c = addr_q;
        state_d    = IDLE;
      end
      default: begin
        busy_c  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Latch the winning command and advance the round-robin pointer
  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      last_q  <= 2'd2;
      win_q   <= 2'd0;
      we_q    <= 1'b0;
      jog_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      last_q  <= pick;
      win_q   <= pick;
      we_q    <= sel_we;
      jog_q   <= sel_jog;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Register the response at the end of ACK. mem_q then holds the row that was read in ACCESS.
  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      ack_q   <= 3'b000;
      erro_q  <= 1'b0;
      rdata_q <= '0;
    end else if (state_q == ACK) begin
      ack_q   <= 3'b001 << win_q;
      erro_q  <= ~addr_ok;
      rdata_q <= addr_ok ? (jog_q ? bus.mem_q2 : bus.mem_q1) : '0;
    end else begin
      ack_q   <= 3'b000;
      erro_q  <= 1'b0;
    end
  end

  // Track which cycles return VGA data, and hold the last VGA row shown
  always_ff @(posedge clk or posedge resetGeral) begin
    if (resetGeral) begin
      vga_valid_q <= 1'b0;
      vga_jog_q   <= 1'b0;
      vga_hold_q  <= '0;
    end else begin
      vga_valid_q <= (state_q == IDLE);
      vga_jog_q   <= bus.vga_jogador;
      vga_hold_q  <= vga_data_c;
    end
  end

  assign vga_data_c = vga_valid_q ? (vga_jog_q ? bus.mem_q2 : bus.mem_q1) : vga_hold_q;

  assign bus.ack       = ack_q;
  assign bus.erro      = erro_q;
  assign bus.rdata     = rdata_q;
  assign bus.vga_data  = vga_data_c;
  assign bus.vga_valid = vga_valid_q;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_data  = wdata_q;
  assign bus.wrenP1    = wren_p1_c;
  assign bus.wrenP2    = wren_p2_c;
  assign bus.busy      = busy_c;

  // The two memories are never written together, and never written outside ACCESS
  a_wren_excl : assert property (@(posedge clk) disable iff (resetGeral)
    !(wren_p1_c && wren_p2_c));
  a_wren_access : assert property (@(posedge clk) disable iff (resetGeral)
    (wren_p1_c || wren_p2_c) |-> (state_q == ACCESS));

endmodule

// File: tb/tb_arbitro_memoria.sv
// Bench for arbitro_memoria: a scoreboard of expected acks plus bench-side models of the two memories.
// Timing: stimulus is driven and outputs are sampled on the falling clock edge.
// Flow: each request is dropped once it is latched, except in the contention case.
module tb_arbitro_memoria;

  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int MAXA = 10;

  logic clk = 1'b0;
  logic resetGeral;
  logic mem_clr;

  always #5 clk = ~clk;

  arbitro_memoria_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  arbitro_memoria #(.ADDR_W(AW), .DATA_W(DW), .MAX_ADDR(MAXA)) dut (
    .clk        (clk),
    .resetGeral (resetGeral),
    .bus        (bus)
  );

  // Board memories: synchronous read that returns the old contents on a same-cycle write
  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] mem2 [32];
  logic [DW-1:0] ref1 [32];
  logic [DW-1:0] ref2 [32];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= 64'h1111_0000_0000_0000 | 64'(i);
        mem2[i] <= 64'h2222_0000_0000_0000 | 64'(i);
      end
    end else begin
      if (bus.wrenP1) mem1[bus.mem_addr] <= bus.mem_data;
      if (bus.wrenP2) mem2[bus.mem_addr] <= bus.mem_data;
    end
    bus.mem_q1 <= mem1[bus.mem_addr];
    bus.mem_q2 <= mem2[bus.mem_addr];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]    ack;
    logic          erro;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sbq [$];
  exp_t mon_e;
  int   ack_seen = 0;

  // Every ack pulse is matched against the oldest expected response
  always @(negedge clk) begin
    if (!resetGeral && bus.ack !== 3'b000) begin
      ack_seen++;
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 64'(bus.ack), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack", 64'(bus.ack), 64'(mon_e.ack));
        chk("erro", 64'(bus.erro), 64'(mon_e.erro));
        chk("rdata", bus.rdata, mon_e.rdata);
        chk("busy_at_ack", 64'(bus.busy), 64'd0);
      end
    end
  end

  // Push the expected response, update the reference memory, then run the request
  // through ACCESS, ACK and the ack cycle.
  task automatic txn(input int idx, input bit we, input bit jog, input int addr, input logic [DW-1:0] data);
    exp_t       ex;
    logic [2:0] oh;
    bit         err;
    @(negedge clk);
    err      = (addr > MAXA);
    oh       = 3'b001 << idx;
    ex.ack   = oh;
    ex.erro  = err;
    ex.rdata = err ? '0 : (jog ? ref2[addr] : ref1[addr]);
    sbq.push_back(ex);
    if (we && !err) begin
      if (jog) ref2[addr] = data;
      else     ref1[addr] = data;
    end
    bus.req                       = oh;
    bus.req_we[idx]               = we;
    bus.req_jogador[idx]          = jog;
    bus.req_addr[idx*AW +: AW]    = addr[AW-1:0];
    bus.req_wdata[idx*DW +: DW]   = data;
    @(posedge clk);
    #1 bus.req = 3'b000;
    @(negedge clk);
    chk("access_wrenP1", 64'(bus.wrenP1), 64'(we && !jog && !err));
    chk("access_wrenP2", 64'(bus.wrenP2), 64'(we && jog && !err));
    chk("access_mem_addr", 64'(bus.mem_addr), 64'(addr));
    chk("access_mem_data", bus.mem_data, data);
    chk("access_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk("ack_state_wren", 64'({bus.wrenP1, bus.wrenP2}), 64'd0);
    chk("ack_state_busy", 64'(bus.busy), 64'd1);
    chk("ack_state_vga_valid", 64'(bus.vga_valid), 64'd0);
    @(negedge clk);
    chk("turnaround", 64'(bus.ack), 64'(oh));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    resetGeral      = 1'b1;
    mem_clr         = 1'b1;
    bus.req         = '0;
    bus.req_we      = '0;
    bus.req_jogador = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.vga_addr    = '0;
    bus.vga_jogador = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ref1[i] = 64'h1111_0000_0000_0000 | 64'(i);
      ref2[i] = 64'h2222_0000_0000_0000 | 64'(i);
    end

    // Outputs while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_erro", 64'(bus.erro), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_vga_data", bus.vga_data, 64'd0);
    chk("rst_vga_valid", 64'(bus.vga_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_wren", 64'({bus.wrenP1, bus.wrenP2}), 64'd0);
    mem_clr    = 1'b0;
    resetGeral = 1'b0;

    // Single P1 write, an out-of-range write, then a P2 write read back by pontuacao
    txn(0, 1'b1, 1'b0, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    txn(1, 1'b1, 1'b0, 11, 64'hBAD0_BAD0_BAD0_BAD0);
    txn(0, 1'b1, 1'b1, 7, 64'h0123);
    txn(2, 1'b0, 1'b0, 7, 64'h0);
    txn(2, 1'b0, 1'b1, 7, 64'h0);
    txn(1, 1'b0, 1'b0, 11, 64'h0);

    // Mixed traffic that includes both address-range boundaries
    for (int k = 0; k < 16; k++) begin
      txn($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 12), {$urandom, $urandom});
    end
    txn(0, 1'b1, 1'b1, 10, 64'hA5A5_0000_0000_000A);
    txn(1, 1'b0, 1'b1, 10, 64'h0);

    // VGA sweep of the P2 rows with no requests pending
    @(negedge clk);
    bus.vga_jogador = 1'b1;
    bus.vga_addr    = 5'd0;
    for (int a = 1; a <= 11; a++) begin
      @(negedge clk);
      chk("vga_valid", 64'(bus.vga_valid), 64'd1);
      chk("vga_data", bus.vga_data, ref2[a-1]);
      if (a <= 10) bus.vga_addr = AW'(a);
    end

    // Reset lands in the ACCESS cycle of a write
    @(negedge clk);
    bus.req            = 3'b001;
    bus.req_we[0]      = 1'b1;
    bus.req_jogador[0] = 1'b0;
    bus.req_addr[0 +: AW] = 5'd5;
    bus.req_wdata[0 +: DW] = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    #1 bus.req = 3'b000;
    @(negedge clk);
    chk("midrst_wren_before", 64'(bus.wrenP1), 64'd1);
    #1 resetGeral = 1'b1;
    #1;
    chk("midrst_wren", 64'({bus.wrenP1, bus.wrenP2}), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_ack", 64'(bus.ack), 64'd0);
    repeat (2) @(negedge clk);
    chk("midrst_ack_held", 64'(bus.ack), 64'd0);
    resetGeral = 1'b0;
    // The aborted write must not have reached the memory
    txn(2, 1'b0, 1'b0, 5, 64'h0);

    // Contention: all three requesters read, with req held from reset
    @(negedge clk);
    resetGeral      = 1'b1;
    bus.req_we      = 3'b000;
    bus.req_jogador = 3'b010;
    bus.req_addr    = {5'd4, 5'd2, 5'd1};
    bus.req         = 3'b111;
    sbq.push_back('{ack: 3'b001, erro: 1'b0, rdata: ref1[1]});
    sbq.push_back('{ack: 3'b010, erro: 1'b0, rdata: ref2[2]});
    sbq.push_back('{ack: 3'b100, erro: 1'b0, rdata: ref1[4]});
    sbq.push_back('{ack: 3'b001, erro: 1'b0, rdata: ref1[1]});
    repeat (2) @(negedge clk);
    resetGeral = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ack !== 3'b000) begin
        cnt++;
        if (cnt == 4) begin
          bus.req = 3'b000;
          break;
        end
      end
    end
    chk("contention_acks", 64'(cnt), 64'd4);
    repeat (6) @(negedge clk);

    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, the board memory address width.
REQ-002 SHALL have parameter DATA_W, default 64, the board row word width.
REQ-003 SHALL have parameter MAX_ADDR, default 10, the highest valid row address.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port resetGeral  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port req  input  3  request vector, bit0 validador, bit1 colisor, bit2 pontuacao.
REQ-007 SHALL have port req_we  input  3  per-requester write flag, 1 = write, 0 = read.
REQ-008 SHALL have port req_jogador  input  3  per-requester player select, 0 = P1 memory, 1 = P2 memory.
REQ-009 SHALL have port req_addr  input  3*ADDR_W  packed per-requester address, requester i in slice i.
REQ-010 SHALL have port req_wdata  input  3*DATA_W  packed per-requester write data, requester i in slice i.
REQ-011 SHALL have port ack  output  3  one-hot completion pulse.
REQ-012 SHALL have port erro  output  1  out-of-range address flag, valid with ack.
REQ-013 SHALL have port rdata  output  DATA_W  read data, valid with ack.
REQ-014 SHALL have port vga_addr  input  ADDR_W  VGA read address.
REQ-015 SHALL have port vga_jogador  input  1  VGA player select.
REQ-016 SHALL have port vga_data  output  DATA_W  VGA read data.
REQ-017 SHALL have port vga_valid  output  1  vga_data valid this cycle.
REQ-018 SHALL have port mem_addr  output  ADDR_W  shared memory address.
REQ-019 SHALL have port mem_data  output  DATA_W  shared memory write data.
REQ-020 SHALL have ports wrenP1 and wrenP2  output  1 each  write enables, P1 and P2 memories.
REQ-021 SHALL have ports mem_q1 and mem_q2  input  DATA_W each  memory read data, 1-cycle synchronous read.
REQ-022 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-023 SHALL implement FSM states IDLE, ACCESS, ACK; transitions: IDLE->ACCESS when any req bit is high; ACCESS->ACK unconditionally; ACK->IDLE unconditionally.
REQ-024 SHALL, in IDLE with req!=0, latch the winner index, we, jogador, addr and wdata at the clock edge.
REQ-025 SHALL select the winner round-robin: search starts at the requester after the last granted one; the pointer after reset makes order validador>colisor>pontuacao.
REQ-026 SHALL, in ACCESS, drive mem_addr = latched addr and mem_data = latched wdata.
REQ-027 SHALL, in ACCESS, assert wrenP1 when we=1, jogador=0 and addr<=MAX_ADDR; wrenP2 likewise for jogador=1; both 0 otherwise.
REQ-028 SHALL, in ACK, pulse ack[winner] for exactly one cycle, with rdata = mem_q1 or mem_q2 per the latched jogador.
REQ-029 SHALL, for addr>MAX_ADDR, suppress writes, assert erro with ack and drive rdata=0.
REQ-030 SHALL give a request in IDLE at edge N an ack in the cycle after edge N+2 (3-cycle turnaround); busy is high in the ACCESS and ACK cycles.
REQ-031 SHALL complete a latched transaction even if its req drops; a requester holding req after ack is re-arbitrated as a new request.
REQ-032 SHALL ignore changes to req inputs during ACCESS/ACK; simultaneous requests are serviced one per transaction in round-robin order.
REQ-033 SHALL, in IDLE, drive mem_addr = vga_addr with both wren low.
REQ-034 SHALL, in the cycle after an IDLE cycle, assert vga_valid with vga_data = mem_q1/mem_q2 per the registered vga_jogador; otherwise vga_valid=0 and vga_data holds its last value.
REQ-035 SHALL never assert wrenP1 and wrenP2 together, and never assert either outside ACCESS.

Reset
REQ-036 SHALL, while resetGeral=1 regardless of clk, force state IDLE, RR pointer to "last=pontuacao", ack=0, erro=0, rdata=0, vga_data=0, vga_valid=0, busy=0, wrenP1=wrenP2=0.
REQ-037 SHALL abort any in-flight transaction on reset with no ack and no write; normal operation resumes on the first edge after deassertion.

Verification
REQ-038 Single write: req=001, we=1, jogador=0, addr=3, wdata=FFFF_FFFF_FFFF_FFFF -> wrenP1=1 for one cycle, mem_addr=3, ack=001 two cycles later, erro=0.
REQ-039 Contention: req=111 held from reset -> acks in order 001, 010, 100, 001 with IDLE cycles between them.
REQ-040 Range error: colisor req, we=1, addr=11 -> no wren, ack=010 with erro=1, rdata=0.
REQ-041 VGA sweep: no req, vga_addr stepping 0..10, vga_jogador=1 -> vga_valid=1 every cycle, vga_data = the P2 row one cycle after each address.
REQ-042 Reset mid-op: assert resetGeral during ACCESS of a write -> wren drops immediately, no ack, busy=0.
REQ-043 Read-back: P2 write of 0x0123 to addr 7, then pontuacao read of addr 7 -> rdata=0x0123 with ack=100.
